// File: rtl/hamming_rx_decoder.sv
// hamming_rx_decoder
//   Serial receive end of the strobed Hamming(7,4) link. Collects c1..c7
//   (c1 first), computes the syndrome {s4,s2,s1}, flips the bit that the
//   syndrome points at and presents the corrected word, data and status.
//   Single-error correction only: double errors are miscorrected.
//   Optional feature: define HAMMING_STATS_EN to add the saturating
//   err_count output that counts corrected frames.

module hamming_rx_decoder #(
    parameter int TIMEOUT = 16
`ifdef HAMMING_STATS_EN
    ,
    parameter int CNT_W   = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_line,
    input  logic             strobe,
    output logic [1:7]       code_out,
    output logic [1:4]       data_out,
    output logic [2:0]       syndrome,
    output logic             valid,
    output logic             err_corrected,
    output logic             frame_err
`ifdef HAMMING_STATS_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] DECODE = 2'd2;

    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [1:6]    sr;
    logic [TW-1:0] tcnt;

    logic [1:7]    word_nx;
    logic [2:0]    syn_nx;
    logic [1:7]    flip_mask;
    logic [1:7]    fixed_nx;
    logic          last_bit;

    // Decode the word as it will be once the incoming bit lands in c7, so
    // the registered result is visible in the cycle right after c7.
    always_comb begin
        word_nx   = {sr, data_line};
        syn_nx[0] = word_nx[1] ^ word_nx[3] ^ word_nx[5] ^ word_nx[7];
        syn_nx[1] = word_nx[2] ^ word_nx[3] ^ word_nx[6] ^ word_nx[7];
        syn_nx[2] = word_nx[4] ^ word_nx[5] ^ word_nx[6] ^ word_nx[7];
        flip_mask = '0;
        if (syn_nx != 3'd0) begin
            flip_mask = 7'b1000000 >> (syn_nx - 3'd1);
        end
        fixed_nx  = word_nx ^ flip_mask;
        last_bit  = (state == SHIFT) && strobe && (cnt == 3'd6);
    end

    // Frame assembly FSM, timeout handling and registered decode outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            sr            <= '0;
            tcnt          <= '0;
            code_out      <= '0;
            data_out      <= '0;
            syndrome      <= '0;
            valid         <= 1'b0;
            err_corrected <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            valid         <= 1'b0;
            err_corrected <= 1'b0;
            frame_err     <= 1'b0;
            case (state)
                // DECODE behaves like IDLE so a strobe there starts the next frame.
                IDLE, DECODE: begin
                    tcnt <= '0;
                    if (strobe) begin
                        sr[1] <= data_line;
                        cnt   <= 3'd1;
                        state <= SHIFT;
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (strobe) begin
                        tcnt <= '0;
                        if (last_bit) begin
                            code_out      <= fixed_nx;
                            data_out      <= {fixed_nx[3], fixed_nx[5], fixed_nx[6], fixed_nx[7]};
                            syndrome      <= syn_nx;
                            err_corrected <= (syn_nx != 3'd0);
                            valid         <= 1'b1;
                            cnt           <= 3'd7;
                            state         <= DECODE;
                        end else begin
                            sr[cnt + 3'd1] <= data_line;
                            cnt            <= cnt + 3'd1;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        frame_err <= 1'b1;
                        cnt       <= '0;
                        tcnt      <= '0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    tcnt  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HAMMING_STATS_EN
    // Saturating count of frames that needed a correction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (last_bit && (syn_nx != 3'd0) && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hamming_rx_decoder.sv
// tb_hamming_rx_decoder
//   Scoreboard bench: each frame sent pushes its expected decode (derived
//   from the data nibble and injected error positions) onto a queue; the
//   monitor pops and compares on every valid pulse.

module tb_hamming_rx_decoder;

    localparam int TO = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_line = 1'b0;
    logic       strobe = 1'b0;
    logic [1:7] code_out;
    logic [1:4] data_out;
    logic [2:0] syndrome;
    logic       valid;
    logic       err_corrected;
    logic       frame_err;
`ifdef HAMMING_STATS_EN
    logic [7:0] err_count;
    int         exp_ec = 0;
`endif

    hamming_rx_decoder #(
        .TIMEOUT(TO)
`ifdef HAMMING_STATS_EN
        ,
        .CNT_W(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_line(data_line),
        .strobe(strobe),
        .code_out(code_out),
        .data_out(data_out),
        .syndrome(syndrome),
        .valid(valid),
        .err_corrected(err_corrected),
        .frame_err(frame_err)
`ifdef HAMMING_STATS_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:7] code;
        logic [1:4] data;
        logic [2:0] syn;
        logic       errc;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fe_seen = 0;
    int   exp_fe = 0;
    bit   b2b = 1'b0;
    int   last_vcyc = -1;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:7] encode(input logic [1:4] d);
        logic [1:7] c;
        c[3] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = d[4];
        c[1] = d[1] ^ d[2] ^ d[4];
        c[2] = d[1] ^ d[3] ^ d[4];
        c[4] = d[2] ^ d[3] ^ d[4];
        return c;
    endfunction

    // Sends one frame; e1/e2 are flipped bit positions (0 = none); an optional
    // gap of gap_len idle cycles follows bit gap_at.
    task automatic send_frame(input logic [1:4] d, input logic [2:0] e1, input logic [2:0] e2,
                              input int gap_at, input int gap_len);
        logic [1:7] tx;
        logic [1:7] fix;
        logic [2:0] s;
        exp_t       e;
        tx = encode(d);
        if (e1 != 3'd0) tx[e1] = ~tx[e1];
        if (e2 != 3'd0) tx[e2] = ~tx[e2];
        s   = e1 ^ e2;
        fix = tx;
        if (s != 3'd0) fix[s] = ~fix[s];
        e.code = fix;
        e.data = {fix[3], fix[5], fix[6], fix[7]};
        e.syn  = s;
        e.errc = (s != 3'd0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            strobe    = 1'b1;
            data_line = tx[i];
            if (i == 7) begin
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    strobe    = 1'b0;
                    data_line = 1'($urandom_range(1));
                end
            end
        end
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            strobe    = 1'b1;
            data_line = 1'($urandom_range(1));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            strobe    = 1'b0;
            data_line = 1'($urandom_range(1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"}, code_out, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_syn"}, syndrome, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_errc"}, err_corrected, 0);
        check({tag, "_frame_err"}, frame_err, 0);
`ifdef HAMMING_STATS_EN
        check({tag, "_err_count"}, err_count, 0);
`endif
    endtask

    // Monitor: pop expected results on valid, enforce status-signal rules.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            check("valid_frame_err_exclusive", valid & frame_err, 0);
            if (frame_err) fe_seen++;
            if (valid) begin
                check("valid_has_pending_frame", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("code_out", code_out, e.code);
                    check("data_out", data_out, e.data);
                    check("syndrome", syndrome, e.syn);
                    check("err_corrected", err_corrected, e.errc);
                    check("latency", cyc, e.cyc);
`ifdef HAMMING_STATS_EN
                    if (e.errc && exp_ec < 255) exp_ec++;
                    check("err_count", err_count, exp_ec);
`endif
                end
                if (b2b && last_vcyc >= 0) check("b2b_spacing", cyc - last_vcyc, 7);
                last_vcyc = cyc;
            end else begin
                check("err_corrected_idle", err_corrected, 0);
            end
        end
    end

    initial begin
        logic [1:4] d;
        logic [2:0] ep;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Clean word, data 1011.
        send_frame(4'b1011, 3'd0, 3'd0, 0, 0);
        idle(3);
        check("t1_data", data_out, 4'b1011);
        check("t1_syn", syndrome, 0);

        // Single error on c5.
        send_frame(4'b1011, 3'd5, 3'd0, 0, 0);
        idle(3);
        check("t2_code", code_out, 7'b0110011);
        check("t2_syn", syndrome, 5);

        // Double error on c1,c2 -> miscorrected.
        send_frame(4'b1011, 3'd1, 3'd2, 0, 0);
        idle(3);
        check("t3_data", data_out, 4'b0011);
        check("t3_syn", syndrome, 3);

        // Gap of TO-1 idle cycles inside a frame must not drop it.
        send_frame(4'b0110, 3'd7, 3'd0, 3, TO - 1);
        idle(3);
        check("gap_below_timeout_no_frame_err", fe_seen, exp_fe);

        // Timeout: 3 bits then TO idle cycles drops the partial frame.
        send_bits(3);
        idle(TO);
        exp_fe++;
        send_frame(4'b1100, 3'd2, 3'd0, 0, 0);
        idle(3);
        check("timeout_frame_err_once", fe_seen, exp_fe);
        check("timeout_next_frame_data", data_out, 4'b1100);

        // Back-to-back frames, strobe every cycle.
        b2b = 1'b1;
        last_vcyc = -1;
        for (int f = 0; f < 3; f++) begin
            d  = 4'($urandom_range(15));
            ep = 3'($urandom_range(7));
            send_frame(d, ep, 3'd0, 0, 0);
        end
        idle(3);
        b2b = 1'b0;

        // Random frames with single/no errors and short gaps.
        for (int f = 0; f < 10; f++) begin
            d  = 4'($urandom_range(15));
            ep = 3'($urandom_range(7));
            send_frame(d, ep, 3'd0, $urandom_range(1, 6), $urandom_range(0, TO - 2));
            idle($urandom_range(0, 2));
        end
        idle(3);

        // Reset mid-frame: outputs clear immediately, partial word discarded.
        send_bits(4);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
`ifdef HAMMING_STATS_EN
        exp_ec = 0;
`endif
        strobe = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(4'b1001, 3'd3, 3'd0, 0, 0);
        idle(3);
        check("post_reset_data", data_out, 4'b1001);

        idle(5);
        check("queue_drained", exp_q.size(), 0);
        check("frame_err_total", fe_seen, exp_fe);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
